nios_ii_system_leds_out: RTL and testbench
==========================================

NIOS_II_SYSTEM_LEDS_OUT -- requirements
Module: nios_ii_system_leds_out

Interface
REQ-001 SHALL have parameter WIDTH, default 8: out_port width, 1..32.
REQ-002 SHALL have parameter BLINK_DIV, default 25000000: clk cycles per blink half-period, minimum 2.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port address  input  3: Avalon-MM register select.
REQ-006 SHALL have port chipselect  input  1: slave select.
REQ-007 SHALL have port write_n  input  1: active-low write strobe; write = chipselect & ~write_n.
REQ-008 SHALL have port writedata  input  32: write data.
REQ-009 SHALL have port readdata  output  32: registered read data, zero-extended.
REQ-010 SHALL have port out_port  output  WIDTH: driven pins (LEDs).
REQ-011 SHALL have port irq  output  1: level interrupt, pulse-complete.

Function
REQ-012 SHALL implement this register map: 0 data RW; 1 pulse_len RW, 16 bits; 2 irq_mask RW, bit0; 3 status (bit0 busy RO, bit1 done; any write clears done); 4 outset W; 5 outclear W; 6 pulse W; 7 blink_mask RW.
REQ-013 SHALL register readdata every cycle from the address-selected mux: one-cycle read latency, independent of chipselect; write-only addresses read 0.
REQ-014 SHALL on an outset write perform data |= writedata[WIDTH-1:0]; on an outclear write perform data &= ~writedata[WIDTH-1:0].
REQ-015 SHALL use a two-state FSM: IDLE and PULSE; busy = (state == PULSE).
REQ-016 SHALL, on a pulse write in IDLE with pulse_len != 0, latch pmask = writedata[WIDTH-1:0], load cnt = pulse_len, and enter PULSE.
REQ-017 SHALL, on a pulse write in IDLE with pulse_len == 0, stay in IDLE and set done on the same edge.
REQ-018 SHALL ignore pulse writes while in PULSE (no restart, no pmask change).
REQ-019 SHALL, in PULSE, decrement cnt each cycle; when cnt == 1, return to IDLE, clear pmask and set done, so PULSE lasts exactly pulse_len cycles.
REQ-020 SHALL compute out_port combinationally from registers as (data ^ (busy ? pmask : 0)) & blink_gate, visible in the cycle after the write edge.
REQ-021 SHALL apply data, outset and outclear writes immediately during PULSE; the XOR overlay continues on top of the new data.
REQ-022 SHALL give set priority when done-set and a status write occur on the same edge (done = 1).
REQ-023 SHALL not affect an active pulse when pulse_len is written during PULSE; the new value applies to the next pulse.
REQ-024 SHALL drive irq = done & irq_mask[0].

Reset
REQ-025 SHALL, on reset_n low, asynchronously clear data, pulse_len, irq_mask, done, pmask, cnt, blink_mask, the blink counter/phase and readdata, and force state to IDLE; out_port = 0, irq = 0.
REQ-026 SHALL, on reset asserted mid-pulse, abort the pulse without setting done.

Configuration
REQ-027 SHALL, with NIOS_II_SYSTEM_LEDS_BLINK_EN defined, toggle phase every BLINK_DIV cycles; blink_gate bit i = ~blink_mask[i] | phase; phase = 1 after reset.
REQ-028 SHALL, without NIOS_II_SYSTEM_LEDS_BLINK_EN, instantiate no blink logic: blink_gate = all ones, address 7 reads 0, and writes to address 7 are ignored.

Structure
REQ-029 SHALL place register address constants, status bit indices and FSM state encodings in package nios_ii_system_leds_pkg.
REQ-030 SHALL implement the blink prescaler as sub-module nios_ii_system_leds_blink_div, instantiated only under the macro.

Verification
REQ-031 SHALL cover: write data=0x0F, then outset 0x30, then outclear 0x03 -> out_port 0x0F, 0x3F, 0x3C; a read of address 0 returns 0x3C one cycle later.
REQ-032 SHALL cover: pulse_len=3, data=0x0F, pulse 0x01 -> out_port 0x0E for exactly 3 cycles, then 0x0F; status reads 0x2.
REQ-033 SHALL cover: irq_mask=1, pulse completes -> irq=1; write status -> irq=0 next cycle; pulse_len=0 with pulse write -> done set immediately.
REQ-034 SHALL cover: pulse_len=10, pulse 0x80, second pulse 0x01 at cycle 4 -> ignored; out_port bit7 inverted for exactly 10 cycles only.
REQ-035 SHALL cover: reset_n low at cycle 2 of a 5-cycle pulse -> out_port=0, busy=0, done=0, irq=0 immediately.
REQ-036 SHALL cover, with macro defined and BLINK_DIV=4: blink_mask=0x01, data=0x01 -> out_port bit0 alternates every 4 cycles; without macro, address 7 reads 0.

Source files
------------

// File: rtl/nios_ii_system_leds_pkg.sv
// nios_ii_system_leds_pkg: register map, status bits and FSM encoding for the LED output port
package nios_ii_system_leds_pkg;
  localparam logic [2:0] ADDR_DATA       = 3'd0;
  localparam logic [2:0] ADDR_PULSE_LEN  = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK   = 3'd2;
  localparam logic [2:0] ADDR_STATUS     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET     = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR   = 3'd5;
  localparam logic [2:0] ADDR_PULSE      = 3'd6;
  localparam logic [2:0] ADDR_BLINK_MASK = 3'd7;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
  typedef enum logic {ST_IDLE = 1'b0, ST_PULSE = 1'b1} state_e;
endpackage

// File: rtl/nios_ii_system_leds_blink_div.sv
// nios_ii_system_leds_blink_div: prescaler toggling phase every BLINK_DIV clocks, phase starts high
module nios_ii_system_leds_blink_div #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset_n,
  output logic phase_o
);
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic phase_q, phase_d, wrap;
  // wrap the counter and flip the phase on its last count
  always_comb begin
    wrap = cnt_q == LAST;
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    phase_d = wrap ? ~phase_q : phase_q;
  end
  // counter and phase registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      phase_q <= phase_d;
    end
  end
  assign phase_o = phase_q;
endmodule

// File: rtl/nios_ii_system_leds_out.sv
// nios_ii_system_leds_out: Avalon-MM LED port with set/clear, timed XOR pulse, irq; blink via NIOS_II_SYSTEM_LEDS_BLINK_EN
module nios_ii_system_leds_out
  import nios_ii_system_leds_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BLINK_DIV = 25000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);
  state_e state_q, state_d;
  logic busy, wr, pulse_wr, pulse_start, pulse_end, unused_wd;
  logic [WIDTH-1:0] wd, data_q, data_d, pmask_q, pmask_d, gate;
  logic [15:0] pulse_len_q, pulse_len_d, cnt_q, cnt_d;
  logic irq_mask_q, irq_mask_d, done_q, done_d;
  logic [31:0] rd_d, readdata_q;
  assign wr = chipselect & ~write_n;
  assign wd = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign pulse_wr = wr && address == ADDR_PULSE;
  assign pulse_start = pulse_wr && state_q == ST_IDLE && pulse_len_q != 16'd0;
  assign pulse_end = state_q == ST_PULSE && cnt_q == 16'd1;
`ifdef NIOS_II_SYSTEM_LEDS_BLINK_EN
  logic phase;
  logic [WIDTH-1:0] blink_mask_q, blink_mask_d;
  nios_ii_system_leds_blink_div #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .clk(clk),
    .reset_n(reset_n),
    .phase_o(phase)
  );
  // blink mask register write
  always_comb blink_mask_d = wr && address == ADDR_BLINK_MASK ? wd : blink_mask_q;
  // blink mask register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) blink_mask_q <= '0;
    else blink_mask_q <= blink_mask_d;
  end
  assign gate = ~blink_mask_q | {WIDTH{phase}};
`else
  assign gate = '1;
`endif
  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else state_q <= state_d;
  end
  // FSM next state: pulse writes only start from IDLE, PULSE ends on the last count
  always_comb state_d = state_q == ST_IDLE ? (pulse_start ? ST_PULSE : ST_IDLE) : (pulse_end ? ST_IDLE : ST_PULSE);
  // FSM output
  always_comb busy = state_q == ST_PULSE;
  // register next-state; done set wins over a same-edge status write
  always_comb begin
    data_d = !wr ? data_q :
             address == ADDR_DATA ? wd :
             address == ADDR_OUTSET ? data_q | wd :
             address == ADDR_OUTCLEAR ? data_q & ~wd : data_q;
    pulse_len_d = wr && address == ADDR_PULSE_LEN ? writedata[15:0] : pulse_len_q;
    irq_mask_d = wr && address == ADDR_IRQ_MASK ? writedata[0] : irq_mask_q;
    done_d = (pulse_wr && state_q == ST_IDLE && pulse_len_q == 16'd0) || pulse_end ? 1'b1 :
             wr && address == ADDR_STATUS ? 1'b0 : done_q;
    pmask_d = pulse_start ? wd : pulse_end ? '0 : pmask_q;
    cnt_d = pulse_start ? pulse_len_q : busy ? cnt_q - 16'd1 : cnt_q;
  end
  // read mux, registered below regardless of chipselect
  always_comb begin
    rd_d = '0;
    case (address)
      ADDR_DATA:      rd_d = 32'(data_q);
      ADDR_PULSE_LEN: rd_d = 32'(pulse_len_q);
      ADDR_IRQ_MASK:  rd_d = 32'(irq_mask_q);
      ADDR_STATUS: begin
        rd_d[STATUS_BUSY_BIT] = busy;
        rd_d[STATUS_DONE_BIT] = done_q;
      end
`ifdef NIOS_II_SYSTEM_LEDS_BLINK_EN
      ADDR_BLINK_MASK: rd_d = 32'(blink_mask_q);
`endif
      default: rd_d = '0;
    endcase
  end
  // control and data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      pulse_len_q <= '0;
      irq_mask_q <= 1'b0;
      done_q <= 1'b0;
      pmask_q <= '0;
      cnt_q <= '0;
      readdata_q <= '0;
    end else begin
      data_q <= data_d;
      pulse_len_q <= pulse_len_d;
      irq_mask_q <= irq_mask_d;
      done_q <= done_d;
      pmask_q <= pmask_d;
      cnt_q <= cnt_d;
      readdata_q <= rd_d;
    end
  end
  assign readdata = readdata_q;
  assign out_port = (data_q ^ (busy ? pmask_q : '0)) & gate;
  assign irq = done_q & irq_mask_q;
endmodule

// File: tb/tb_nios_ii_system_leds_out.sv
// tb_nios_ii_system_leds_out: directed stimulus with a cycle-tagged scoreboard checked at each falling edge
module tb_nios_ii_system_leds_out;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] address = '0;
  logic chipselect = 1'b0;
  logic write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0] out_port;
  logic irq;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int cyc;
    int sel;
    logic [31:0] exp;
    string name;
  } exp_t;
  exp_t sb[$];

  nios_ii_system_leds_out #(.WIDTH(8), .BLINK_DIV(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port),
    .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    int i;
    logic [31:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        act = sb[i].sel == 0 ? {24'b0, out_port} : sb[i].sel == 1 ? readdata : {31'b0, irq};
        checks++;
        if (act !== sb[i].exp) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%h exp=%h", sb[i].name, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end else i++;
    end
  end

  task automatic expect_at(input string n, input int sel, input int off, input logic [31:0] e);
    exp_t x;
    x.cyc = cyc + off;
    x.sel = sel;
    x.exp = e;
    x.name = n;
    sb.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    address = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, sb.size());
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    @(posedge clk);
    #1;
    expect_at("rst_out", 0, 0, 32'h0);
    expect_at("rst_rd", 1, 0, 32'h0);
    expect_at("rst_irq", 2, 0, 32'h0);
    idle(1);
    reset_n = 1'b1;
    idle(1);
    wr(3'd0, 32'h0F);
    expect_at("data_wr", 0, 0, 32'h0F);
    wr(3'd4, 32'h30);
    expect_at("outset", 0, 0, 32'h3F);
    wr(3'd5, 32'h03);
    expect_at("outclear", 0, 0, 32'h3C);
    rd(3'd0);
    expect_at("rd_data", 1, 0, 32'h3C);
    rd(3'd4);
    expect_at("rd_wo4", 1, 0, 32'h0);
    rd(3'd6);
    expect_at("rd_wo6", 1, 0, 32'h0);
    wr(3'd1, 32'h3);
    rd(3'd1);
    expect_at("rd_plen", 1, 0, 32'h3);
    wr(3'd0, 32'h0F);
    wr(3'd6, 32'h01);
    for (int k = 0; k < 3; k++) expect_at("pulse3_on", 0, k, 32'h0E);
    expect_at("pulse3_off", 0, 3, 32'h0F);
    rd(3'd3);
    expect_at("status_busy", 1, 0, 32'h1);
    idle(2);
    rd(3'd3);
    expect_at("status_done", 1, 0, 32'h2);
    expect_at("irq_masked", 2, 0, 32'h0);
    wr(3'd3, 32'h0);
    expect_at("irq_clr0", 2, 0, 32'h0);
    wr(3'd2, 32'h1);
    expect_at("irq_nodone", 2, 0, 32'h0);
    wr(3'd6, 32'h02);
    expect_at("pulse2_out", 0, 0, 32'h0D);
    expect_at("irq_before", 2, 2, 32'h0);
    expect_at("irq_done", 2, 3, 32'h1);
    idle(3);
    wr(3'd3, 32'h0);
    expect_at("irq_cleared", 2, 0, 32'h0);
    wr(3'd1, 32'h0);
    wr(3'd6, 32'h01);
    expect_at("plen0_irq", 2, 0, 32'h1);
    expect_at("plen0_out", 0, 0, 32'h0F);
    rd(3'd3);
    expect_at("plen0_status", 1, 0, 32'h2);
    wr(3'd3, 32'h0);
    expect_at("irq_clr1", 2, 0, 32'h0);
    wr(3'd1, 32'h3);
    wr(3'd6, 32'h01);
    idle(2);
    wr(3'd3, 32'h0);
    expect_at("set_priority", 2, 0, 32'h1);
    wr(3'd3, 32'h0);
    expect_at("irq_clr2", 2, 0, 32'h0);
    wr(3'd1, 32'd10);
    wr(3'd6, 32'h80);
    for (int k = 0; k < 12; k++)
      expect_at("pulse10", 0, k, k < 6 ? 32'h8F : k < 10 ? 32'hCF : 32'h4F);
    idle(3);
    wr(3'd6, 32'h01);
    idle(1);
    wr(3'd4, 32'h40);
    wr(3'd1, 32'h2);
    idle(4);
    rd(3'd1);
    expect_at("plen_after", 1, 0, 32'h2);
    wr(3'd3, 32'h0);
    wr(3'd1, 32'h5);
    wr(3'd6, 32'h01);
    expect_at("pulse5_on", 0, 0, 32'h4E);
    idle(1);
    reset_n = 1'b0;
    expect_at("abort_out", 0, 0, 32'h0);
    expect_at("abort_irq", 2, 0, 32'h0);
    expect_at("abort_rd", 1, 0, 32'h0);
    idle(2);
    reset_n = 1'b1;
    rd(3'd3);
    expect_at("abort_status", 1, 0, 32'h0);
    expect_at("abort_irq2", 2, 0, 32'h0);
    rd(3'd0);
    expect_at("abort_data", 1, 0, 32'h0);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
`ifdef NIOS_II_SYSTEM_LEDS_BLINK_EN
    wr(3'd7, 32'h01);
    wr(3'd0, 32'h01);
    for (int k = 0; k < 14; k++)
      expect_at("blink", 0, k, (k < 2 || (k >= 6 && k < 10)) ? 32'h1 : 32'h0);
    idle(14);
    rd(3'd7);
    expect_at("rd_blink_mask", 1, 0, 32'h1);
`else
    wr(3'd7, 32'hFF);
    wr(3'd0, 32'h01);
    for (int k = 0; k < 8; k++) expect_at("noblink", 0, k, 32'h1);
    idle(8);
    rd(3'd7);
    expect_at("rd_addr7", 1, 0, 32'h0);
`endif
    idle(2);
    if (sb.size() != 0) begin
      failures += sb.size();
      $display("FAIL scoreboard pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
